// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO arbiter / burst scheduler slice.
// The read scheduler state is exported so checkers can observe it.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_BURST_LEN = 4;
  // Beat counter must hold any burst length up to 255.
  localparam int BEAT_W        = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin write arbiter: combinational grant, registered pointer.
// rr_ptr names the requester that wins when both ask in the same cycle.
module rr_arb2 (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic req0,
  input  logic req1,
  input  logic block,
  output logic grant0,
  output logic grant1
);

  logic rr_ptr;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!sys_rst && !block) begin
      if (req0 && (!req1 || !rr_ptr)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
  end

  // After a grant, priority passes to the requester that was not served.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_arb_sched.sv
// Shares one synchronous FIFO between two writers and drains it to a single
// consumer in fixed-length read bursts, with a flush that drains a final partial burst.
module fifo_arb_sched
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_data_count,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output sched_state_t      sched_state
);

  // Handshake: a requester word transfers in any cycle where valid and ready are
  // both high (ready is a same-cycle accept); out_valid beats cannot be stalled.

  localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BURST_BEATS = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] ONE_BEAT    = BEAT_W'(1);

  logic grant0, grant1;

  sched_state_t      state, state_next;
  logic [BEAT_W-1:0] beat_cnt, beat_next;
  logic              flush_pend, flush_clr;

  rr_arb2 u_arb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .block   (fifo_full),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign fifo_wr_en   = grant0 | grant1;
  assign fifo_wr_data = grant1 ? req1_data : req0_data;

  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    flush_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_data_count >= BURST_CNT) begin
          beat_next  = BURST_BEATS;
          state_next = BURST;
        end else if (flush_pend && !fifo_empty) begin
          // Partial burst sized to occupancy, so the read never underruns.
          beat_next  = BEAT_W'(fifo_data_count);
          state_next = BURST;
        end else if (flush_pend) begin
          flush_clr = 1'b1;
        end
      end
      BURST: begin
        beat_next = beat_cnt - ONE_BEAT;
        if (beat_cnt == ONE_BEAT) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // fifo_rd_en is registered from the next state, so it is high exactly in BURST cycles.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      fifo_rd_en <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state      <= state_next;
      beat_cnt   <= beat_next;
      flush_pend <= flush | (flush_pend & ~flush_clr);
      fifo_rd_en <= (state_next == BURST);
      out_valid  <= fifo_rd_en;
      out_last   <= (state == BURST) && (beat_cnt == ONE_BEAT);
    end
  end

  assign out_data    = fifo_rd_data;
  assign sched_state = state;

endmodule
